booth_mul: RTL

Sequential signed radix-2 Booth multiplier, the multiply counterpart to the team's non-restoring divider in the arithmetic datapath. It accepts two N-bit two's-complement operands on a one-cycle `start` and produces a 2N-bit signed product after N iteration cycles. It uses the same start/done handshake as the divider, so both blocks can sit behind one arithmetic-unit sequencer.

---
 rtl/arith_pkg.sv | 15 +
 rtl/booth_step.sv | 33 +++
 rtl/booth_mul.sv | 83 ++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (Booth multiplier, divider sequencer).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Booth recoding of the {Q[0], Q_1} pair
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic shift of {A,Q,Q_1}.
module booth_step
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N:0]   m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next,
  output logic         q_1_next
);

  logic [N:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      BOOTH_NOP: sum = a;
      default:   sum = a;
    endcase
  end

  // A is one bit wider than the operands, so its MSB is the true sign to replicate
  assign a_next   = {sum[N], sum[N:1]};
  assign q_next   = {sum[0], q[N-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential signed radix-2 Booth multiplier with start/busy/done handshake; N iterations per product.
module booth_mul
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  state_t          state_reg;
  logic [N:0]      a_reg;
  logic [N:0]      m_reg;
  logic [N-1:0]    q_reg;
  logic            q1_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N:0]      a_next;
  logic [N-1:0]    q_next;
  logic            q1_next;

  booth_step #(.N(N)) u_step (
    .a        (a_reg),
    .q        (q_reg),
    .q_1      (q1_reg),
    .m        (m_reg),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q1_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q1_reg    <= 1'b0;
      cnt_reg   <= '0;
      product   <= '0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= '0;
            q_reg     <= multiplier;
            q1_reg    <= 1'b0;
            m_reg     <= {multiplicand[N-1], multiplicand};
            cnt_reg   <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          a_reg   <= a_next;
          q_reg   <= q_next;
          q1_reg  <= q1_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1))
            state_reg <= FINISH;
        end
        FINISH: begin
          // A[N] is only a guard bit; the product always fits in 2N signed bits
          product   <= {a_reg[N-1:0], q_reg};
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
